// File: rtl/reg_op_scheduler.sv
// reg_op_scheduler
//   Arbitrated sequencer for a 4-entry signed register file (r0..r3) that
//   shares one add/sub unit between two requesters. At most one micro-op
//   (dst <= srcA op srcB/imm) executes per clock.
//
//   States: IDLE -> INIT (loads r0..r3, one per cycle) -> RUN -> DONE after
//   MAX_OPS accepted ops. DONE -> INIT again on start.
//
//   Optional feature macro: REG_OP_SAT_EN
//     defined   : ADD/SUB/ADDI saturate on signed overflow
//     undefined : results wrap modulo 2^DW
//     MOV is unaffected in both cases.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               level; begins INIT from IDLE or DONE
//   reqN_valid/ready    N=0,1 handshake; op accepted when valid & ready
//   reqN_op             0 ADD, 1 SUB, 2 ADDI, 3 MOV
//   reqN_dst/srca/srcb  register indices (srcb ignored for ADDI/MOV)
//   reqN_imm            immediate
//   regs                {r3,r2,r1,r0}, registered
//   busy / done         state is INIT or RUN / state is DONE
//   op_count            ops accepted in the current run
module reg_op_scheduler #(
    parameter int DW      = 32,
    parameter int INIT_R0 = 30,
    parameter int INIT_R1 = 20,
    parameter int INIT_R2 = 15,
    parameter int INIT_R3 = 5,
    parameter int MAX_OPS = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           req0_valid,
    output logic                           req0_ready,
    input  logic [1:0]                     req0_op,
    input  logic [1:0]                     req0_dst,
    input  logic [1:0]                     req0_srca,
    input  logic [1:0]                     req0_srcb,
    input  logic [DW-1:0]                  req0_imm,
    input  logic                           req1_valid,
    output logic                           req1_ready,
    input  logic [1:0]                     req1_op,
    input  logic [1:0]                     req1_dst,
    input  logic [1:0]                     req1_srca,
    input  logic [1:0]                     req1_srcb,
    input  logic [DW-1:0]                  req1_imm,
    output logic [4*DW-1:0]                regs,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(MAX_OPS+1)-1:0]   op_count
);

    localparam int CW = $clog2(MAX_OPS + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_INIT = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MOV = 2'd3;

    logic [1:0]          state_reg, state_next;
    logic [1:0]          init_idx_reg;
    logic [CW-1:0]       op_count_reg;
    logic                last_reg;      // 1: req1 was granted last
    logic [3:0][DW-1:0]  rf;

    function automatic logic [DW-1:0] init_value(input int idx);
        case (idx)
            0:       init_value = DW'(INIT_R0);
            1:       init_value = DW'(INIT_R1);
            2:       init_value = DW'(INIT_R2);
            default: init_value = DW'(INIT_R3);
        endcase
    endfunction

    // Round-robin: a lone requester wins; on a tie the one not granted last wins.
    logic grant0, grant1, run, accept, final_op;
    assign grant0     = req0_valid & (~req1_valid | last_reg);
    assign grant1     = req1_valid & (~req0_valid | ~last_reg);
    assign run        = (state_reg == ST_RUN);
    assign req0_ready = run & grant0;
    assign req1_ready = run & grant1;
    assign accept     = req0_ready | req1_ready;
    assign final_op   = accept && (op_count_reg == CW'(MAX_OPS - 1));

    // Fields of the winning request
    logic [1:0]    op_sel, dst_sel, srca_sel, srcb_sel;
    logic [DW-1:0] imm_sel;
    assign op_sel   = req1_ready ? req1_op   : req0_op;
    assign dst_sel  = req1_ready ? req1_dst  : req0_dst;
    assign srca_sel = req1_ready ? req1_srca : req0_srca;
    assign srcb_sel = req1_ready ? req1_srcb : req0_srcb;
    assign imm_sel  = req1_ready ? req1_imm  : req0_imm;

    // Operands come from the current register values, so an op whose source
    // is also its destination reads the old value.
    logic [DW-1:0] opa, opb, arith, result;
    assign opa = rf[srca_sel];
    assign opb = op_sel[1] ? imm_sel : rf[srcb_sel];   // ADDI/MOV use imm

`ifdef REG_OP_SAT_EN
    // One guard bit: overflow when the two top bits disagree.
    logic [DW:0] ext_sum;
    assign ext_sum = (op_sel == OP_SUB) ? ({opa[DW-1], opa} - {opb[DW-1], opb})
                                        : ({opa[DW-1], opa} + {opb[DW-1], opb});
    assign arith = (ext_sum[DW] != ext_sum[DW-1])
                 ? (ext_sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}})
                 : ext_sum[DW-1:0];
`else
    assign arith = (op_sel == OP_SUB) ? (opa - opb) : (opa + opb);
`endif

    assign result = (op_sel == OP_MOV) ? imm_sel : arith;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_INIT;
            ST_INIT: if (init_idx_reg == 2'd3) state_next = ST_RUN;
            ST_RUN:  if (final_op) state_next = ST_DONE;
            ST_DONE: if (start) state_next = ST_INIT;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            init_idx_reg <= 2'd0;
            op_count_reg <= '0;
            last_reg     <= 1'b1;
        end else begin
            state_reg    <= state_next;
            init_idx_reg <= (state_reg == ST_INIT) ? init_idx_reg + 2'd1 : 2'd0;
            if ((state_reg == ST_IDLE || state_reg == ST_DONE) && start)
                op_count_reg <= '0;
            else if (accept)
                op_count_reg <= op_count_reg + CW'(1);
            if (accept)
                last_reg <= req1_ready;
        end
    end

    // One register per entry; INIT and op writes never overlap in time.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_reg
            logic [DW-1:0] r_reg;
            logic          init_we;
            assign init_we = (state_reg == ST_INIT) && (init_idx_reg == 2'(gi));
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_reg <= '0;
                else if (init_we)
                    r_reg <= init_value(gi);
                else if (accept && dst_sel == 2'(gi))
                    r_reg <= result;
            end
            assign rf[gi] = r_reg;
        end
    endgenerate

    assign regs     = rf;
    assign busy     = (state_reg == ST_INIT) || (state_reg == ST_RUN);
    assign done     = (state_reg == ST_DONE);
    assign op_count = op_count_reg;

endmodule

// File: tb/tb_reg_op_scheduler.sv
module tb_reg_op_scheduler;

    localparam int DW = 32;
    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_SUB  = 2'd1;
    localparam logic [1:0] OP_ADDI = 2'd2;
    localparam logic [1:0] OP_MOV  = 2'd3;
`ifdef REG_OP_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n, start;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0]    req0_op, req0_dst, req0_srca, req0_srcb;
    logic [1:0]    req1_op, req1_dst, req1_srca, req1_srcb;
    logic [DW-1:0] req0_imm, req1_imm;
    logic [4*DW-1:0] regs;
    logic          busy, done;
    logic [4:0]    op_count;

    reg_op_scheduler dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_dst(req0_dst), .req0_srca(req0_srca), .req0_srcb(req0_srcb), .req0_imm(req0_imm),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_dst(req1_dst), .req1_srca(req1_srca), .req1_srcb(req1_srcb), .req1_imm(req1_imm),
        .regs(regs), .busy(busy), .done(done), .op_count(op_count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          who;           // 0 = req0, 1 = req1
        logic [1:0]  op, dst, sa, sb;
        logic [31:0] imm;
        logic [31:0] exp_w;         // expected result, wrapping build
        logic [31:0] exp_s;         // expected result, saturating build
    } vec_t;

    typedef struct {
        logic [1:0]  dst;
        logic [31:0] val;
        int          cnt;
    } sb_t;

    vec_t tbl [8];
    sb_t  sbq [$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    bit   mdl_last = 1'b1;     // 1: req1 granted last
    int   mdl_cnt = 0;

    localparam logic [127:0] INIT_REGS = {32'd5, 32'd15, 32'd20, 32'd30};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] rval(input logic [1:0] i);
        return regs[i*DW +: DW];
    endfunction

    task automatic clr_req();
        req0_valid = 0; req1_valid = 0;
    endtask

    task automatic set_req(input int n, input logic [1:0] op, dst, sa, sb, input logic [31:0] imm);
        if (n == 0) begin
            req0_valid = 1; req0_op = op; req0_dst = dst; req0_srca = sa; req0_srcb = sb; req0_imm = imm;
        end else begin
            req1_valid = 1; req1_op = op; req1_dst = dst; req1_srca = sa; req1_srcb = sb; req1_imm = imm;
        end
    endtask

    // One RUN cycle: check the grant against the arbiter model, push the
    // expected write, clock, then pop and compare the visible result.
    task automatic cycle(input string tag, input logic [31:0] exp0, exp1, output int g);
        sb_t e;
        #1;
        if (req0_valid && req1_valid) g = mdl_last ? 0 : 1;
        else if (req0_valid)          g = 0;
        else if (req1_valid)          g = 1;
        else                          g = -1;
        chk({tag, " ready"}, {req1_ready, req0_ready},
            (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00);
        if (g >= 0) begin
            mdl_cnt++;
            mdl_last = (g == 1);
            e.dst = (g == 0) ? req0_dst : req1_dst;
            e.val = (g == 0) ? exp0 : exp1;
            e.cnt = mdl_cnt;
            sbq.push_back(e);
        end
        @(posedge clk); @(negedge clk);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk({tag, " reg"}, rval(e.dst), e.val);
            chk({tag, " cnt"}, op_count, e.cnt);
            $display("txn %s grant=req%0d r%0d=%h (want %h) op_count=%0d",
                     tag, g, e.dst, rval(e.dst), e.val, op_count);
        end
    endtask

    task automatic init_seq(input string tag);
        start = 1;
        @(negedge clk);
        start = 0;
        for (int k = 0; k < 4; k++) begin
            chk({tag, " init busy"}, busy, 1'b1);
            chk({tag, " init done"}, done, 1'b0);
            chk({tag, " init cnt"}, op_count, 0);
            @(negedge clk);
        end
        chk({tag, " init regs"}, regs, INIT_REGS);
        chk({tag, " run busy"}, busy, 1'b1);
        $display("txn %s init complete regs=%h", tag, regs);
    endtask

    initial begin
        int g, n0, n1;
        // ADD d0=r1+r2, ADDI d3=r0-3, SUB d1=r3-r2, MOV r2=max, ADDI overflow,
        // SUB across the positive limit, MOV r3=min, SUB below the negative limit.
        tbl[0] = '{0, OP_ADD,  2'd0, 2'd1, 2'd2, 32'd0,         32'd35,        32'd35};
        tbl[1] = '{0, OP_ADDI, 2'd3, 2'd0, 2'd0, 32'hFFFF_FFFD, 32'd32,        32'd32};
        tbl[2] = '{0, OP_SUB,  2'd1, 2'd3, 2'd2, 32'd0,         32'd17,        32'd17};
        tbl[3] = '{0, OP_MOV,  2'd2, 2'd0, 2'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
        tbl[4] = '{0, OP_ADDI, 2'd2, 2'd2, 2'd0, 32'd1,         32'h8000_0000, 32'h7FFF_FFFF};
        tbl[5] = '{0, OP_SUB,  2'd0, 2'd2, 2'd1, 32'd0,         32'h7FFF_FFEF, 32'h7FFF_FFEE};
        tbl[6] = '{0, OP_MOV,  2'd3, 2'd0, 2'd0, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        tbl[7] = '{1, OP_SUB,  2'd3, 2'd3, 2'd1, 32'd0,         32'h7FFF_FFEF, 32'h8000_0000};

        rst_n = 0; start = 0;
        req0_valid = 0; req0_op = 0; req0_dst = 0; req0_srca = 0; req0_srcb = 0; req0_imm = 0;
        req1_valid = 0; req1_op = 0; req1_dst = 0; req1_srca = 0; req1_srcb = 0; req1_imm = 0;
        repeat (2) @(negedge clk);

        chk("reset regs", regs, 0);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset ready", {req1_ready, req0_ready}, 2'b00);
        chk("reset cnt", op_count, 0);

        rst_n = 1;
        set_req(0, OP_MOV, 2'd0, 2'd0, 2'd0, 32'd77);
        @(negedge clk);
        chk("idle busy", busy, 1'b0);
        chk("idle ready", req0_ready, 1'b0);
        chk("idle regs", regs, 0);
        clr_req();

        init_seq("first");

        for (int i = 0; i < 8; i++) begin
            clr_req();
            set_req(tbl[i].who, tbl[i].op, tbl[i].dst, tbl[i].sa, tbl[i].sb, tbl[i].imm);
            cycle($sformatf("vec%0d", i), SAT ? tbl[i].exp_s : tbl[i].exp_w,
                  SAT ? tbl[i].exp_s : tbl[i].exp_w, g);
        end

        // Both requesters valid every cycle; each changes its op only once
        // accepted. start is held high to show it is ignored in RUN.
        n0 = 0; n1 = 0;
        start = 1;
        for (int k = 0; k < 4; k++) begin
            clr_req();
            set_req(0, OP_MOV, 2'd0, 2'd0, 2'd0, 32'(100 + n0));
            set_req(1, OP_MOV, 2'd1, 2'd0, 2'd0, 32'(200 + n1));
            cycle("arb", 32'(100 + n0), 32'(200 + n1), g);
            if (g == 0) n0++; else n1++;
        end
        start = 0;

        for (int k = 0; k < 4; k++) begin
            clr_req();
            set_req(0, OP_MOV, 2'd3, 2'd0, 2'd0, 32'(500 + k));
            cycle($sformatf("fill%0d", k), 32'(500 + k), 32'(500 + k), g);
        end

        chk("done flag", done, 1'b1);
        chk("done busy", busy, 1'b0);
        chk("done cnt", op_count, 16);
        #1;
        chk("done ready", {req1_ready, req0_ready}, 2'b00);
        set_req(0, OP_MOV, 2'd3, 2'd0, 2'd0, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("done hold r3", rval(2'd3), 32'd503);
        chk("done hold cnt", op_count, 16);
        $display("txn done state held op_count=%0d r3=%h", op_count, rval(2'd3));
        clr_req();

        init_seq("restart");

        // Asynchronous reset with a valid op pending; nothing may be written.
        set_req(0, OP_MOV, 2'd0, 2'd0, 2'd0, 32'd999);
        #1;
        chk("pre-rst ready", req0_ready, 1'b1);
        #2;
        rst_n = 0;
        #1;
        chk("rst regs", regs, 0);
        chk("rst busy", busy, 1'b0);
        chk("rst cnt", op_count, 0);
        chk("rst ready", {req1_ready, req0_ready}, 2'b00);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("post-rst regs", regs, 0);
        chk("post-rst busy", busy, 1'b0);
        $display("txn reset during run regs=%h busy=%0b", regs, busy);
        clr_req();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
